// File: rtl/oled_power_sequencer.sv
// SSD1306 power-up sequencer: switches the VDD/RES/VBAT rails in order, runs
// the delay generator for the settle times and streams init command bytes to
// the SPI serializer. initDone rises once the panel is on.
//
// Handshakes (valid/ready style, both directions):
//   delayEn  is a level request. It is held until delayDone is sampled high,
//            then dropped for at least one cycle before any new request.
//   spiLoad  is a level request with spiData stable while it is high. It is
//            held until spiDone is sampled high, then dropped for at least one
//            cycle before the next byte.
//   A delayDone or spiDone pulse that arrives while the matching request is
//   low is ignored.
module oled_power_sequencer #(
    parameter int LONG_REPS = 50,
    parameter int CMD_A_LEN = 4,
    parameter int CMD_B_LEN = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       delayEn,
    input  logic       delayDone,
    output logic [7:0] spiData,
    output logic       spiLoad,
    input  logic       spiDone,
    output logic       oledDc,
    output logic       oledRes,
    output logic       oledVdd,
    output logic       oledVbat,
    output logic       initDone,
    output logic [3:0] fsmState
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        VDD_ON    = 4'd1,
        WAIT_VDD  = 4'd2,
        DISP_OFF  = 4'd3,
        RES_LO    = 4'd4,
        WAIT_RES  = 4'd5,
        RES_HI    = 4'd6,
        WAIT_RES2 = 4'd7,
        CMD_A     = 4'd8,
        VBAT_ON   = 4'd9,
        WAIT_LONG = 4'd10,
        CMD_B     = 4'd11,
        DISP_ON   = 4'd12,
        DONE      = 4'd13
    } state_t;

    state_t     state;
    logic [2:0] byteIdx;
    logic [5:0] repCnt;

    // Commands sent before VBAT is switched on: charge pump on, pre-charge period.
    function automatic logic [7:0] cmdA(input logic [2:0] idx);
        case (idx)
            3'd0:    cmdA = 8'h8D;
            3'd1:    cmdA = 8'h14;
            3'd2:    cmdA = 8'hD9;
            3'd3:    cmdA = 8'hF1;
            default: cmdA = 8'h00;
        endcase
    endfunction

    // Commands sent after the long VBAT settle: contrast, segment/COM remap, COM config.
    function automatic logic [7:0] cmdB(input logic [2:0] idx);
        case (idx)
            3'd0:    cmdB = 8'h81;
            3'd1:    cmdB = 8'h0F;
            3'd2:    cmdB = 8'hA1;
            3'd3:    cmdB = 8'hC8;
            3'd4:    cmdB = 8'hDA;
            3'd5:    cmdB = 8'h00;
            default: cmdB = 8'h00;
        endcase
    endfunction

    // This block only ever sends commands.
    assign oledDc   = 1'b0;
    assign fsmState = state;

    // Sequencer FSM: one step per edge, every output registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            byteIdx  <= 3'd0;
            repCnt   <= 6'd0;
            delayEn  <= 1'b0;
            spiLoad  <= 1'b0;
            spiData  <= 8'h00;
            oledRes  <= 1'b1;
            oledVdd  <= 1'b1;
            oledVbat <= 1'b1;
            initDone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= VDD_ON;
                end
                VDD_ON: begin
                    oledVdd <= 1'b0;
                    delayEn <= 1'b1;
                    state   <= WAIT_VDD;
                end
                WAIT_VDD: begin
                    if (delayEn && delayDone) begin
                        delayEn <= 1'b0;
                        state   <= DISP_OFF;
                    end
                end
                DISP_OFF: begin
                    if (!spiLoad) begin
                        spiData <= 8'hAE;
                        spiLoad <= 1'b1;
                    end else if (spiDone) begin
                        spiLoad <= 1'b0;
                        state   <= RES_LO;
                    end
                end
                RES_LO: begin
                    oledRes <= 1'b0;
                    delayEn <= 1'b1;
                    state   <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (delayEn && delayDone) begin
                        delayEn <= 1'b0;
                        state   <= RES_HI;
                    end
                end
                RES_HI: begin
                    oledRes <= 1'b1;
                    delayEn <= 1'b1;
                    state   <= WAIT_RES2;
                end
                WAIT_RES2: begin
                    if (delayEn && delayDone) begin
                        delayEn <= 1'b0;
                        byteIdx <= 3'd0;
                        state   <= CMD_A;
                    end
                end
                CMD_A: begin
                    if (!spiLoad) begin
                        spiData <= cmdA(byteIdx);
                        spiLoad <= 1'b1;
                    end else if (spiDone) begin
                        spiLoad <= 1'b0;
                        if (byteIdx == 3'(CMD_A_LEN - 1)) begin
                            byteIdx <= 3'd0;
                            state   <= VBAT_ON;
                        end else begin
                            byteIdx <= byteIdx + 3'd1;
                        end
                    end
                end
                VBAT_ON: begin
                    oledVbat <= 1'b0;
                    repCnt   <= 6'd0;
                    delayEn  <= 1'b1;
                    state    <= WAIT_LONG;
                end
                WAIT_LONG: begin
                    // Re-request after the one idle cycle between periods.
                    if (!delayEn) begin
                        delayEn <= 1'b1;
                    end else if (delayDone) begin
                        delayEn <= 1'b0;
                        if (repCnt == 6'(LONG_REPS - 1)) begin
                            byteIdx <= 3'd0;
                            state   <= CMD_B;
                        end else begin
                            repCnt <= repCnt + 6'd1;
                        end
                    end
                end
                CMD_B: begin
                    if (!spiLoad) begin
                        spiData <= cmdB(byteIdx);
                        spiLoad <= 1'b1;
                    end else if (spiDone) begin
                        spiLoad <= 1'b0;
                        if (byteIdx == 3'(CMD_B_LEN - 1)) begin
                            byteIdx <= 3'd0;
                            state   <= DISP_ON;
                        end else begin
                            byteIdx <= byteIdx + 3'd1;
                        end
                    end
                end
                DISP_ON: begin
                    if (!spiLoad) begin
                        spiData <= 8'hAF;
                        spiLoad <= 1'b1;
                    end else if (spiDone) begin
                        spiLoad  <= 1'b0;
                        initDone <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_power_sequencer.sv
// Bench for oled_power_sequencer: delay and SPI stubs with programmable
// latency, a byte scoreboard, rail-order and handshake monitors.
module tb_oled_power_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stray_start = 1'b0;
  logic       delayDone = 1'b0;
  logic       spiDone = 1'b0;
  logic       delayEn, spiLoad, oledDc, oledRes, oledVdd, oledVbat, initDone;
  logic [7:0] spiData;
  logic [3:0] fsmState;

  int n_compared = 0;
  int n_mismatched = 0;

  // stub / monitor state
  bit   mon_en = 0, spurious_en = 0, inject_start = 0, injected = 0;
  int   dly_lat = 5, spi_lat = 8, dly_cnt = 0, spi_cnt = 0;
  int   periods = 0, res_low_periods = 0, bytes_done = 0;
  logic prev_den = 0, prev_sload = 0, prev_dacc = 0, prev_sacc = 0;
  logic prev_res = 1, prev_vbat = 1;
  logic [7:0] prev_sdata = 8'h00;
  logic [7:0] exp_q[$];

  // clock/reset block
  always #5 clock = ~clock;

  oled_power_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start | stray_start),
    .delayEn   (delayEn),
    .delayDone (delayDone),
    .spiData   (spiData),
    .spiLoad   (spiLoad),
    .spiDone   (spiDone),
    .oledDc    (oledDc),
    .oledRes   (oledRes),
    .oledVdd   (oledVdd),
    .oledVbat  (oledVbat),
    .initDone  (initDone),
    .fsmState  (fsmState)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stubs and monitors: inputs driven on the falling edge from outputs seen there.
  always @(negedge clock) begin
    logic dacc, sacc;
    logic [31:0] exp_byte;
    delayDone = 1'b0;
    spiDone = 1'b0;
    stray_start = 1'b0;
    if (delayEn) begin
      dly_cnt = prev_den ? dly_cnt + 1 : 1;
      if (dly_cnt == dly_lat) delayDone = 1'b1;
    end else if (spurious_en && $urandom_range(0, 5) == 0) begin
      delayDone = 1'b1;
    end
    if (spiLoad) begin
      spi_cnt = prev_sload ? spi_cnt + 1 : 1;
      if (spi_cnt == spi_lat) spiDone = 1'b1;
    end else if (spurious_en && $urandom_range(0, 5) == 0) begin
      spiDone = 1'b1;
    end
    dacc = delayDone && delayEn;
    sacc = spiDone && spiLoad;
    if (mon_en) begin
      if (prev_dacc) check_eq("delayEn_drop", delayEn, 0);
      if (prev_sacc) check_eq("spiLoad_drop", spiLoad, 0);
      if (prev_sload && spiLoad) check_eq("spiData_hold", spiData, prev_sdata);
      if (prev_res && !oledRes) check_eq("vdd_before_res", oledVdd, 0);
      if (prev_vbat && !oledVbat) check_eq("vbat_after_cmd_a", bytes_done, 5);
      if (dacc) begin
        periods++;
        if (!oledRes) res_low_periods++;
      end
      if (sacc) begin
        exp_byte = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD;
        check_eq("spi_byte", spiData, exp_byte);
        check_eq("vbat_at_byte", oledVbat, (bytes_done < 5) ? 1 : 0);
        check_eq("dc_cmd", oledDc, 0);
        bytes_done++;
      end
      if (inject_start && !injected && spiLoad && spiData == 8'h8D) begin
        stray_start = 1'b1;
        injected = 1;
      end
    end
    prev_den = delayEn;
    prev_sload = spiLoad;
    prev_sdata = spiData;
    prev_dacc = dacc;
    prev_sacc = sacc;
    prev_res = oledRes;
    prev_vbat = oledVbat;
  end

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_delayEn"}, delayEn, 0);
    check_eq({pfx, "_spiLoad"}, spiLoad, 0);
    check_eq({pfx, "_spiData"}, spiData, 8'h00);
    check_eq({pfx, "_oledDc"}, oledDc, 0);
    check_eq({pfx, "_oledRes"}, oledRes, 1);
    check_eq({pfx, "_oledVdd"}, oledVdd, 1);
    check_eq({pfx, "_oledVbat"}, oledVbat, 1);
    check_eq({pfx, "_initDone"}, initDone, 0);
  endtask

  task automatic apply_reset(input string pfx);
    @(negedge clock); #1;
    mon_en = 0;
    spurious_en = 0;
    reset = 1'b1;
    @(negedge clock); #1;
    check_reset_values(pfx);
    reset = 1'b0;
  endtask

  // driver: arm the model and pulse start
  task automatic start_sequence(input int dl, input int sl, input bit spur, input bit inj);
    dly_lat = dl;
    spi_lat = sl;
    spurious_en = spur;
    inject_start = inj;
    injected = 0;
    exp_q = {8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h00, 8'hAF};
    periods = 0;
    res_low_periods = 0;
    bytes_done = 0;
    mon_en = 1;
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
  endtask

  task automatic finish_sequence();
    int cyc;
    cyc = 0;
    while (!initDone && cyc < 5000) begin
      @(negedge clock); #1;
      cyc++;
    end
    check_eq("init_done", initDone, 1);
    check_eq("delay_periods", periods, 3 + 50);
    check_eq("bytes_left", exp_q.size(), 0);
    check_eq("res_low_periods", res_low_periods, 1);
    check_eq("final_outputs", {oledVdd, oledRes, oledVbat, delayEn, spiLoad}, 5'b01000);
    if (inject_start) check_eq("stray_start_sent", injected, 1);
    spurious_en = 0;
    mon_en = 0;
  endtask

  initial begin
    int cyc;
    // 1: reset held 3 cycles, then idle with no start
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check_reset_values("rst");
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock); #1;
      check_reset_values("idle");
    end

    // 2-4: nominal latencies
    start_sequence(5, 8, 0, 0);
    finish_sequence();

    // 5: reset during the long wait at rep 20, then replay
    apply_reset("rst2");
    start_sequence(5, 8, 0, 0);
    cyc = 0;
    while (periods < 23 && cyc < 5000) begin
      @(negedge clock); #1;
      cyc++;
    end
    check_eq("reach_rep20", periods, 23);
    @(negedge clock); #1;
    check_eq("vbat_on_in_long_wait", oledVbat, 0);
    mon_en = 0;
    reset = 1'b1;
    @(negedge clock); #1;
    check_eq("midrst_vbat", oledVbat, 1);
    check_eq("midrst_vdd", oledVdd, 1);
    check_eq("midrst_delayEn", delayEn, 0);
    check_eq("midrst_res", oledRes, 1);
    reset = 1'b0;
    start_sequence(5, 8, 0, 0);
    finish_sequence();

    // 6: spurious done pulses in IDLE, then a stray start during CMD_A
    apply_reset("rst3");
    spurious_en = 1;
    repeat (3) begin
      repeat (6) @(negedge clock);
      #1;
      check_reset_values("spur_idle");
    end
    spurious_en = 0;
    start_sequence(5, 8, 0, 1);
    finish_sequence();

    // randomized latencies with spurious pulses
    for (int r = 0; r < 4; r++) begin
      apply_reset("rst_rand");
      start_sequence($urandom_range(1, 10), $urandom_range(1, 10), 1, 1'($urandom_range(0, 1)));
      finish_sequence();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
